reg_scoreboard: RTL and testbench

Register-file hazard scheduler for the pipelined RV core. It tracks in-flight writes to the 32 architectural registers and gates instruction issue from decode until all source operands and the destination are safe to use. It sits between decode/issue and the writeback stage, with a kill path from the branch/flush logic. Register x0 is never tracked.

---
 rtl/reg_scoreboard_pkg.sv | 25 ++
 rtl/reg_scoreboard_sb_counter.sv | 48 ++++
 rtl/reg_scoreboard.sv | 97 +++++++++
 tb/tb_reg_scoreboard.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared register-file constants and scoreboard defaults for the RV core.
// Also provides the destination decoder used by the scoreboard top level.
package reg_scoreboard_pkg;

  localparam int REG_ADDR_WIDTH  = 5;
  localparam int REG_NUM         = 32;

  // Scoreboard defaults; they do not depend on the datapath width.
  localparam int SB_CNT_WIDTH    = 2;
  localparam int SB_MAX_INFLIGHT = 3;

  // One-hot decode of a register address. Bit 0 (x0) does not exist in the
  // result, so events that target x0 cannot reach any counter.
  function automatic logic [REG_NUM-1:1] reg_onehot(
    input logic                      en,
    input logic [REG_ADDR_WIDTH-1:0] addr
  );
    logic [REG_NUM-1:1] v;
    for (int r = 1; r < REG_NUM; r++) begin
      v[r] = en && (addr == REG_ADDR_WIDTH'(r));
    end
    return v;
  endfunction

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// sb_counter: in-flight write counter for one architectural register.
// Takes one increment and up to two decrements per cycle; clamps at both ends.
module sb_counter #(
  parameter int CNT_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 dec_wb,
  input  logic                 dec_kill,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic [CNT_WIDTH-1:0] cnt_nxt,
  output logic                 underflow
);

  // One extra bit so the +1/-2 arithmetic never wraps.
  localparam int EW = CNT_WIDTH + 1;

  logic [EW-1:0] up;
  logic [EW-1:0] dec;
  logic [EW-1:0] diff;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    up        = {1'b0, cnt} + EW'(inc);
    dec       = EW'(dec_wb) + EW'(dec_kill);
    diff      = up - dec;
    underflow = 1'b0;
    cnt_nxt   = cnt;
    if (up < dec) begin
      underflow = 1'b1;
      cnt_nxt   = '0;
    end else if (diff[CNT_WIDTH]) begin
      cnt_nxt   = '1;
    end else begin
      cnt_nxt   = diff[CNT_WIDTH-1:0];
    end
  end

  // NOTE: state is written with non-blocking assignments so every flop
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks in-flight register writes and gates decode issue.
// Optional macro SCOREBOARD_BYPASS_EN lets a same-cycle final writeback clear hazards.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_WIDTH    = SB_CNT_WIDTH,
  parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic                      issue_we,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rs1,
  input  logic                      issue_rs1_used,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rs2,
  input  logic                      issue_rs2_used,
  output logic                      issue_stall,
  output logic                      issue_fire,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic                      kill_valid,
  input  logic [REG_ADDR_WIDTH-1:0] kill_rd,
  output logic [REG_NUM-1:0]        busy_mask,
  output logic                      err
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_INFLIGHT);
  localparam logic [CNT_WIDTH-1:0] ONE_CNT = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt     [REG_NUM];
  logic [CNT_WIDTH-1:0] cnt_nxt [1:REG_NUM-1];
  logic [REG_NUM-1:1]   inc_dec;
  logic [REG_NUM-1:1]   wb_dec;
  logic [REG_NUM-1:1]   kill_dec;
  logic [REG_NUM-1:1]   uflow;
  logic [REG_NUM-1:0]   busy_nxt;

  logic hazard_rs1;
  logic hazard_rs2;
  logic waw_full;
  logic [CNT_WIDTH-1:0] rd_cnt;

  // Address decoders; only issues that actually leave decode count.
  assign inc_dec  = reg_onehot(issue_fire & issue_we, issue_rd);
  assign wb_dec   = reg_onehot(wb_valid, wb_rd);
  assign kill_dec = reg_onehot(kill_valid, kill_rd);

  // x0 reads as an idle register so the hazard lookups need no special case.
  assign cnt[0]      = '0;
  assign busy_nxt[0] = 1'b0;

  for (genvar g = 1; g < REG_NUM; g++) begin : g_reg
    sb_counter #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc_dec[g]),
      .dec_wb    (wb_dec[g]),
      .dec_kill  (kill_dec[g]),
      .cnt       (cnt[g]),
      .cnt_nxt   (cnt_nxt[g]),
      .underflow (uflow[g])
    );
    assign busy_nxt[g] = (cnt_nxt[g] != '0);
  end

  always_comb begin
    hazard_rs1 = issue_rs1_used && (cnt[issue_rs1] != '0);
    hazard_rs2 = issue_rs2_used && (cnt[issue_rs2] != '0);
    rd_cnt     = cnt[issue_rd];
`ifdef SCOREBOARD_BYPASS_EN
    // The last outstanding write retiring this cycle is forwarded by the
    // register file, so the reader need not wait for the count to drop.
    if (wb_valid && (wb_rd == issue_rs1) && (cnt[issue_rs1] == ONE_CNT)) hazard_rs1 = 1'b0;
    if (wb_valid && (wb_rd == issue_rs2) && (cnt[issue_rs2] == ONE_CNT)) hazard_rs2 = 1'b0;
    if (wb_valid && (wb_rd == issue_rd) && (rd_cnt != '0)) rd_cnt = rd_cnt - ONE_CNT;
`endif
    // Writeback is in order, so only a full counter blocks a WAW issue.
    waw_full    = issue_we && (issue_rd != '0) && (rd_cnt == MAX_CNT);
    issue_stall = !rst && issue_valid && (hazard_rs1 || hazard_rs2 || waw_full);
  end

  assign issue_fire = issue_valid & ~issue_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_mask <= '0;
      err       <= 1'b0;
    end else begin
      busy_mask <= busy_nxt;
      err       <= err | (|uflow);
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard (default or bypass build).
// Expected values are hand-derived from the scoreboard behaviour.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_we, issue_rs1_used, issue_rs2_used;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_stall, issue_fire;
  logic        wb_valid, kill_valid;
  logic [4:0]  wb_rd, kill_rd;
  logic [31:0] busy_mask;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_we       (issue_we),
    .issue_rd       (issue_rd),
    .issue_rs1      (issue_rs1),
    .issue_rs1_used (issue_rs1_used),
    .issue_rs2      (issue_rs2),
    .issue_rs2_used (issue_rs2_used),
    .issue_stall    (issue_stall),
    .issue_fire     (issue_fire),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .kill_valid     (kill_valid),
    .kill_rd        (kill_rd),
    .busy_mask      (busy_mask),
    .err            (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_we = 0; issue_rd = 0;
    issue_rs1 = 0; issue_rs1_used = 0; issue_rs2 = 0; issue_rs2_used = 0;
    wb_valid = 0; wb_rd = 0; kill_valid = 0; kill_rd = 0;
  endtask

  task automatic set_issue(input logic v, input logic we, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2);
    issue_valid = v; issue_we = we; issue_rd = rd;
    issue_rs1 = rs1; issue_rs1_used = u1; issue_rs2 = rs2; issue_rs2_used = u2;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    tick(); tick();
    checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want %h", busy_mask, 32'h0); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    rst = 0;
  endtask

  task automatic test_basic();
    set_issue(1, 1, 5, 0, 0, 0, 0); #1;
    checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL basic_fire_rd5: got %b want 1", issue_fire); end
    tick(); idle();
    checks++; if (busy_mask !== 32'h0000_0020) begin errors++; $display("FAIL basic_busy5: got %h want %h", busy_mask, 32'h20); end
    set_issue(1, 0, 0, 5, 1, 0, 0); #1;
    checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL basic_raw_stall: got %b want 1", issue_stall); end
    wb_valid = 1; wb_rd = 5; #1;
`ifdef SCOREBOARD_BYPASS_EN
    checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL basic_bypass_fire: got %b want 1", issue_fire); end
    tick(); idle();
    checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL basic_busy_clear: got %h want %h", busy_mask, 32'h0); end
`else
    checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL basic_wb_cycle_stall: got %b want 1", issue_stall); end
    tick(); wb_valid = 0; #1;
    checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL basic_busy_clear: got %h want %h", busy_mask, 32'h0); end
    checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL basic_fire_after_wb: got %b want 1", issue_fire); end
    tick(); idle();
`endif
  endtask

  task automatic test_x0();
    set_issue(1, 1, 0, 0, 0, 0, 0); #1;
    checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL x0_fire_rd0: got %b want 1", issue_fire); end
    tick();
    set_issue(1, 0, 0, 0, 1, 0, 1);
    wb_valid = 1; wb_rd = 0; kill_valid = 1; kill_rd = 0; #1;
    checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL x0_rs_stall: got %b want 0", issue_stall); end
    tick(); idle();
    checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL x0_busy: got %h want %h", busy_mask, 32'h0); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL x0_err: got %b want 0", err); end
  endtask

  task automatic test_waw();
    for (int k = 0; k < 3; k++) begin
      set_issue(1, 1, 7, 0, 0, 0, 0); #1;
      checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL waw_fire_%0d: got %b want 1", k, issue_fire); end
      tick();
    end
    idle();
    checks++; if (busy_mask !== 32'h0000_0080) begin errors++; $display("FAIL waw_busy7: got %h want %h", busy_mask, 32'h80); end
    set_issue(1, 1, 7, 0, 0, 0, 0); #1;
    checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL waw_full_stall: got %b want 1", issue_stall); end
    wb_valid = 1; wb_rd = 7; #1;
`ifdef SCOREBOARD_BYPASS_EN
    checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL waw_bypass_fire: got %b want 1", issue_fire); end
    tick(); idle();
`else
    checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL waw_wb_cycle_stall: got %b want 1", issue_stall); end
    tick(); wb_valid = 0; #1;
    checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL waw_fire_after_wb: got %b want 1", issue_fire); end
    tick(); idle();
`endif
    // Three writes remain outstanding on x7.
    for (int k = 0; k < 3; k++) begin
      wb_valid = 1; wb_rd = 7; tick(); idle();
      if (k == 1) begin
        checks++; if (busy_mask !== 32'h0000_0080) begin errors++; $display("FAIL waw_drain_busy: got %h want %h", busy_mask, 32'h80); end
      end
    end
    checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL waw_drained: got %h want %h", busy_mask, 32'h0); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL waw_err: got %b want 0", err); end
  endtask

  task automatic test_issue_wb_same();
    set_issue(1, 1, 9, 0, 0, 0, 0); tick();
    wb_valid = 1; wb_rd = 9; tick(); idle();
    checks++; if (busy_mask !== 32'h0000_0200) begin errors++; $display("FAIL same_busy9: got %h want %h", busy_mask, 32'h200); end
    wb_valid = 1; wb_rd = 9; tick(); idle();
    checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL same_cnt_was_1: got %h want %h", busy_mask, 32'h0); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL same_err: got %b want 0", err); end
  endtask

  task automatic test_kill();
    set_issue(1, 1, 20, 0, 0, 0, 0); tick(); idle();
    checks++; if (busy_mask !== 32'h0010_0000) begin errors++; $display("FAIL kill_busy20: got %h want %h", busy_mask, 32'h0010_0000); end
    set_issue(1, 0, 0, 0, 0, 20, 1); #1;
    checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL kill_rs2_stall: got %b want 1", issue_stall); end
    issue_rs2_used = 0; #1;
    checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL kill_rs2_unused: got %b want 0", issue_stall); end
    idle(); kill_valid = 1; kill_rd = 20; tick(); idle();
    checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL kill_busy_clear: got %h want %h", busy_mask, 32'h0); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL kill_err: got %b want 0", err); end
  endtask

  task automatic test_wb_kill();
    set_issue(1, 1, 12, 0, 0, 0, 0); tick(); tick(); idle();
    checks++; if (busy_mask !== 32'h0000_1000) begin errors++; $display("FAIL wbkill_busy12: got %h want %h", busy_mask, 32'h1000); end
    wb_valid = 1; wb_rd = 12; kill_valid = 1; kill_rd = 12; tick(); idle();
    checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL wbkill_busy_clear: got %h want %h", busy_mask, 32'h0); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wbkill_err0: got %b want 0", err); end
    wb_valid = 1; wb_rd = 12; tick(); idle();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL underflow_err: got %b want 1", err); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
    checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL underflow_clamp: got %h want %h", busy_mask, 32'h0); end
  endtask

  task automatic test_reset_mid();
    set_issue(1, 1, 3, 0, 0, 0, 0); tick(); tick(); idle();
    checks++; if (busy_mask !== 32'h0000_0008) begin errors++; $display("FAIL rmid_busy3: got %h want %h", busy_mask, 32'h8); end
    rst = 1; set_issue(1, 0, 0, 3, 1, 0, 0); #1;
    checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL rmid_stall_in_rst: got %b want 0", issue_stall); end
    tick(); rst = 0; #1;
    checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL rmid_busy: got %h want %h", busy_mask, 32'h0); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rmid_err: got %b want 0", err); end
    checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL rmid_stall_after: got %b want 0", issue_stall); end
    idle(); tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_x0();
    test_waw();
    test_issue_wb_same();
    test_kill();
    test_wb_kill();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
